// File: rtl/pkt_wrr_arbiter.sv
// Weighted round-robin packet arbiter for four sources sharing one output.
// Each source receives up to cfg_weight packets per round. Grants last whole
// packets (held until eop_in). Credits are refilled from cfg_weight in a
// dedicated RELOAD cycle once every requesting source has used its credit.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   req          - per-source packet-available flags
//   cfg_weight   - 4-bit weight per source (source i at [4i+3:4i], 0 means 1)
//   out_alf      - downstream almost-full, blocks new grants
//   eop_in       - last beat of the granted packet has been forwarded
//   grant        - registered one-hot grant
//   busy         - OR of grant bits
//   pkt_total    - wrapping count of completed packets
module pkt_wrr_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req,
   input  logic [15:0] cfg_weight,
   input  logic        out_alf,
   input  logic        eop_in,
   output logic [3:0]  grant,
   output logic        busy,
   output logic [31:0] pkt_total
);

   localparam int unsigned N_SRC = 4;
   localparam int unsigned CW    = 4;
   localparam int unsigned PW    = 2;
   localparam int unsigned CNT_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      RELOAD = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [N_SRC-1:0]   grant_q, grant_d;
   logic [CW-1:0]      credit_q [N_SRC];
   logic [CW-1:0]      credit_d [N_SRC];
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [CNT_W-1:0]   total_q, total_d;

   logic               found;
   logic [PW-1:0]      pick;
   logic [PW-1:0]      owner;

   // First eligible source (req set, credit left) searching from ptr upward.
   always_comb begin
      logic [PW-1:0] idx;
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         idx = ptr_q + PW'(i);
         if (!found && req[idx] && (credit_q[idx] != '0)) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   // Index of the currently granted source.
   always_comb begin
      owner = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (grant_q[i]) owner = PW'(i);
      end
   end

   // Next-state and datapath updates.
   always_comb begin
      logic [CW-1:0] dec;
      logic [CW-1:0] w;
      state_d  = state_q;
      grant_d  = grant_q;
      ptr_d    = ptr_q;
      total_d  = total_q;
      credit_d = credit_q;
      dec      = '0;
      w        = '0;
      case (state_q)
         IDLE: begin
            if (!out_alf && (req != '0)) begin
               if (found) begin
                  grant_d = N_SRC'(1) << pick;
                  state_d = GRANT;
               end else begin
                  // Requests pending but no credit anywhere they matter.
                  state_d = RELOAD;
               end
            end
         end
         GRANT: begin
            if (eop_in) begin
               dec             = (credit_q[owner] != '0) ? credit_q[owner] - CW'(1) : '0;
               credit_d[owner] = dec;
               ptr_d           = (dec != '0) ? owner : owner + PW'(1);
               total_d         = total_q + CNT_W'(1);
               grant_d         = '0;
               state_d         = IDLE;
            end
         end
         RELOAD: begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
               w           = cfg_weight[CW*i +: CW];
               credit_d[i] = (w == '0) ? CW'(1) : w;
            end
            state_d = IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         total_q <= '0;
         for (int unsigned i = 0; i < N_SRC; i++) credit_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         ptr_q    <= ptr_d;
         total_q  <= total_d;
         credit_q <= credit_d;
      end
   end

   assign grant     = grant_q;
   assign busy      = |grant_q;
   assign pkt_total = total_q;

endmodule
